// File: rtl/interrupt_request_unit.sv
// interrupt_request_unit: synchronises external interrupt lines, latches
// rising edges as pending requests and sequences one take/return at a time.
// Ports:
//   clock, reset        : rising-edge clock, async active-high reset
//   irq_in              : async request lines, one per source
//   intr_enable         : global interrupt enable from the enable control
//   inst_boundary       : current instruction completes this cycle
//   memInstOpcode       : opcode of the current instruction
//   pc_next             : return address captured on a take
//   intr, intr_return   : one-cycle take / return pulses
//   intr_vector, epc    : handler address and saved return address
//   intr_id             : index of the taken source
//   pending             : latched pending requests
//   in_service          : high while a handler is executing
module interrupt_request_unit #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          ID_WIDTH      = 2,
  parameter logic [31:0] VECTOR_BASE   = 32'd256,
  parameter logic [31:0] VECTOR_STRIDE = 32'd4,
  localparam int         NUM_SRC       = 2**ID_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    irq_in,
  input  logic                  intr_enable,
  input  logic                  inst_boundary,
  input  logic [5:0]            memInstOpcode,
  input  logic [DATA_WIDTH-1:0] pc_next,
  output logic                  intr,
  output logic                  intr_return,
  output logic [DATA_WIDTH-1:0] intr_vector,
  output logic [DATA_WIDTH-1:0] epc,
  output logic [ID_WIDTH-1:0]   intr_id,
  output logic [NUM_SRC-1:0]    pending,
  output logic                  in_service
);

  localparam logic [5:0] OP_RETURN = 6'b101100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    SERVICE = 2'd2,
    RET     = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_SRC-1:0]    s1;
  logic [NUM_SRC-1:0]    s2;
  logic [NUM_SRC-1:0]    s3;
  logic [NUM_SRC-1:0]    rise;
  logic [NUM_SRC-1:0]    clr;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [DATA_WIDTH-1:0] vec_calc;
  logic                  take;
  logic                  is_ret;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Scan downward so the lowest set index wins.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) sel_id = ID_WIDTH'(i);
    end
  end

  assign vec_calc = DATA_WIDTH'(VECTOR_BASE)
                  + DATA_WIDTH'(VECTOR_STRIDE)
                  * DATA_WIDTH'(sel_id);

  assign take = (state == IDLE) & intr_enable
              & inst_boundary & (|pending);

  assign is_ret = inst_boundary
                & (memInstOpcode == OP_RETURN);

  assign clr = take ? (NUM_SRC'(1) << sel_id) : '0;

  // A fresh edge on the clearing edge re-sets the bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      intr_id     <= '0;
      epc         <= '0;
      intr_vector <= '0;
    end else if (take) begin
      intr_id     <= sel_id;
      epc         <= pc_next;
      intr_vector <= vec_calc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = ACK;
      ACK:     state_nxt = SERVICE;
      SERVICE: if (is_ret) state_nxt = RET;
      RET:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    intr        = (state == ACK);
    intr_return = (state == RET);
    in_service  = (state == ACK) | (state == SERVICE);
  end

endmodule

// File: tb/tb_interrupt_request_unit.sv
// tb_interrupt_request_unit: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the request unit.
module tb_interrupt_request_unit;

  localparam logic [5:0] OP_RET = 6'b101100;

  logic        clock;
  logic        reset;
  logic [3:0]  irq;
  logic        en;
  logic        bnd;
  logic [5:0]  op;
  logic [31:0] pc;
  logic        intr;
  logic        intr_return;
  logic [31:0] intr_vector;
  logic [31:0] epc;
  logic [1:0]  intr_id;
  logic [3:0]  pending;
  logic        in_service;

  int n_tests = 0;
  int n_fail  = 0;

  interrupt_request_unit dut (
    .clock         (clock),
    .reset         (reset),
    .irq_in        (irq),
    .intr_enable   (en),
    .inst_boundary (bnd),
    .memInstOpcode (op),
    .pc_next       (pc),
    .intr          (intr),
    .intr_return   (intr_return),
    .intr_vector   (intr_vector),
    .epc           (epc),
    .intr_id       (intr_id),
    .pending       (pending),
    .in_service    (in_service)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: the line value sampled at each edge becomes visible as a
  // rising edge two samples later; phase 0..3 = idle/ack/svc/ret.
  logic [3:0]  h1, h2, h3;
  logic [3:0]  m_pend;
  int          m_ph;
  logic [1:0]  m_id;
  logic [31:0] m_epc;
  logic [31:0] m_vec;

  always @(posedge clock or posedge reset) begin
    logic [3:0] p;
    int         id;
    if (reset) begin
      h1 <= '0; h2 <= '0; h3 <= '0;
      m_pend <= '0; m_ph <= 0;
      m_id <= '0; m_epc <= '0; m_vec <= '0;
    end else begin
      p = m_pend;
      case (m_ph)
        0: if (en && bnd && p != 4'd0) begin
             id = 0;
             while (!p[id]) id++;
             p[id] = 1'b0;
             m_id  <= 2'(id);
             m_epc <= pc;
             m_vec <= 32'd256 + 32'(id) * 32'd4;
             m_ph  <= 1;
           end
        1: m_ph <= 2;
        2: if (bnd && op == OP_RET) m_ph <= 3;
        default: m_ph <= 0;
      endcase
      m_pend <= p | (h2 & ~h3);
      h3 <= h2;
      h2 <= h1;
      h1 <= irq;
    end
  end

  always @(negedge clock) begin
    #1;
    check("m_intr", 32'(intr), 32'(m_ph == 1));
    check("m_ret", 32'(intr_return), 32'(m_ph == 3));
    check("m_insvc", 32'(in_service),
          32'(m_ph == 1 || m_ph == 2));
    check("m_pend", 32'(pending), 32'(m_pend));
    check("m_id", 32'(intr_id), 32'(m_id));
    check("m_epc", epc, m_epc);
    check("m_vec", intr_vector, m_vec);
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    irq = '0; en = 1'b0; bnd = 1'b0;
    op = '0; pc = '0;
    ticks(2);
    reset = 1'b0;
    ticks(2);

    // single request on source 2
    irq = 4'b0100; en = 1'b1; bnd = 1'b1;
    pc = 32'h40;
    ticks(3);
    check("sr_pend", 32'(pending), 32'h4);
    check("sr_nointr", 32'(intr), 32'h0);
    tick();
    check("sr_intr", 32'(intr), 32'h1);
    check("sr_id", 32'(intr_id), 32'd2);
    check("sr_vec", intr_vector, 32'd264);
    check("sr_epc", epc, 32'h40);
    check("sr_pend0", 32'(pending), 32'h0);
    op = OP_RET;
    tick();
    check("sr_svc", 32'(in_service), 32'h1);
    check("sr_pulse1", 32'(intr), 32'h0);
    tick();
    check("sr_ret", 32'(intr_return), 32'h1);
    check("sr_ret_svc", 32'(in_service), 32'h0);
    op = '0;
    tick();
    check("sr_ret1", 32'(intr_return), 32'h0);

    // priority between sources 1 and 3
    en = 1'b0; irq = '0;
    ticks(3);
    irq = 4'b1010;
    ticks(3);
    check("pr_pend", 32'(pending), 32'ha);
    en = 1'b1;
    tick();
    check("pr_intr", 32'(intr), 32'h1);
    check("pr_id", 32'(intr_id), 32'd1);
    check("pr_vec", intr_vector, 32'd260);
    check("pr_pend1", 32'(pending), 32'h8);
    op = OP_RET;
    ticks(2);
    check("pr_ret", 32'(intr_return), 32'h1);
    op = '0;
    ticks(2);
    check("pr_intr2", 32'(intr), 32'h1);
    check("pr_id2", 32'(intr_id), 32'd3);
    check("pr_vec2", intr_vector, 32'd268);
    op = OP_RET;
    ticks(2);
    op = '0;
    tick();

    // accumulation while disabled
    en = 1'b0; irq = '0;
    ticks(3);
    irq = 4'b0101;
    ticks(4);
    check("da_pend", 32'(pending), 32'h5);
    check("da_nointr", 32'(intr), 32'h0);
    en = 1'b1;
    tick();
    check("da_intr", 32'(intr), 32'h1);
    check("da_id", 32'(intr_id), 32'd0);

    // no nesting, return gated by boundary
    tick();
    irq = 4'b0111; op = OP_RET; bnd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("nn_intr", 32'(intr), 32'h0);
      check("nn_ret", 32'(intr_return), 32'h0);
      check("nn_svc", 32'(in_service), 32'h1);
    end
    bnd = 1'b1;
    tick();
    check("nn_ret1", 32'(intr_return), 32'h1);
    check("nn_svc0", 32'(in_service), 32'h0);
    op = '0; en = 1'b0;
    ticks(3);

    // edge on source 0 lands on its own take edge
    irq = 4'b0110;
    ticks(3);
    irq = 4'b0111;
    ticks(4);
    irq = 4'b0110;
    ticks(3);
    irq = 4'b0111;
    ticks(2);
    en = 1'b1;
    tick();
    check("co_intr", 32'(intr), 32'h1);
    check("co_id", 32'(intr_id), 32'd0);
    check("co_p0", 32'(pending[0]), 32'h1);

    // reset mid-service, line held high through reset
    tick();
    check("rs_svc", 32'(in_service), 32'h1);
    reset = 1'b1;
    #1;
    check("rs_intr", 32'(intr), 32'h0);
    check("rs_ret", 32'(intr_return), 32'h0);
    check("rs_svc0", 32'(in_service), 32'h0);
    check("rs_pend", 32'(pending), 32'h0);
    check("rs_id", 32'(intr_id), 32'h0);
    check("rs_epc", epc, 32'h0);
    check("rs_vec", intr_vector, 32'h0);
    ticks(2);
    reset = 1'b0;
    ticks(3);
    check("rs_hold", 32'(pending), 32'h7);
    check("rs_hold_i", 32'(intr), 32'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 5) == 0)
        irq = irq ^ 4'(1 << $urandom_range(0, 3));
      en  = ($urandom_range(0, 3) != 0);
      bnd = ($urandom_range(0, 2) != 0);
      op  = ($urandom_range(0, 2) == 0) ?
            OP_RET : 6'($urandom());
      pc  = $urandom();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_request_unit.md
# interrupt_request_unit

Upstream companion to the interrupt-enable control. Synchronises external interrupt lines and latches rising edges as pending requests. When interrupts are enabled and the current instruction completes, it selects the highest-priority request, saves the return PC, and pulses `intr`; that pulse clears the enable flag and redirects the PC to a handler vector. It tracks the in-service interrupt until a RETURN instruction completes, then pulses `intr_return` so the PC mux restores `epc`.

## Interface
- `DATA_WIDTH`, 32, width of PC/address values
- `ID_WIDTH`, 2, source index width; number of sources `NUM_SRC` = 2**ID_WIDTH
- `VECTOR_BASE`, 32'd256, handler address of source 0
- `VECTOR_STRIDE`, 32'd4, address distance between consecutive source handlers
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `irq_in`  in  NUM_SRC  external request lines, asynchronous to `clock`
- `intr_enable`  in  1  interrupt-enable state from the enable control (1 = ON)
- `inst_boundary`  in  1  high for one cycle when the current instruction completes and the PC updates on the next edge
- `memInstOpcode`  in  6  opcode of the current instruction (memInst[31:26])
- `pc_next`  in  DATA_WIDTH  address of the next sequential instruction (return address)
- `intr`  out  1  one-cycle interrupt-taken pulse
- `intr_return`  out  1  one-cycle return-taken pulse
- `intr_vector`  out  DATA_WIDTH  handler address; valid from the `intr` cycle, held until the next take
- `epc`  out  DATA_WIDTH  saved return address; held until the next take
- `intr_id`  out  ID_WIDTH  index of the taken source; held until the next take
- `pending`  out  NUM_SRC  latched pending requests
- `in_service`  out  1  high while a handler is executing

## Operation
- Per source: two-flop synchroniser (s1, s2) plus a history flop s3. A rising edge is `s2 & ~s3`; it sets `pending[i]`.
- Repeated edges on a source whose pending bit is already set coalesce into that one bit. Requests accumulate while disabled and are never dropped.
- FSM states:
  - IDLE: if `intr_enable & inst_boundary & |pending`, go to ACK. On that edge, latch the following and clear `pending[id]`:
    - `intr_id` = lowest set pending index (index 0 has the highest priority)
    - `epc` = `pc_next`
    - `intr_vector` = VECTOR_BASE + id*VECTOR_STRIDE, truncated to DATA_WIDTH
  - ACK: `intr`=1 for exactly this cycle. Unconditionally go to SERVICE.
  - SERVICE: `in_service`=1. If `inst_boundary & memInstOpcode==6'b101100` (RETURN), go to RET.
  - RET: `intr_return`=1 for one cycle, `in_service`=0. Go to IDLE.
- `in_service` is 1 in both ACK and SERVICE.
- No nesting: no take occurs in ACK, SERVICE, or RET, regardless of `intr_enable`.
- If a new edge arrives on the same edge that clears that source's pending bit, the set wins and the bit stays 1.
- A RETURN opcode seen while in IDLE is ignored.

## Timing
- Reset (asynchronous) forces:
  - all outputs to 0 (`intr`, `intr_return`, `intr_vector`, `epc`, `intr_id`, `pending`, `in_service`)
  - s1, s2, s3 to 0
  - the FSM to IDLE
- A line held high through reset is seen as one rising edge after release.
- Latency from `irq_in[i]` rising before edge n:
  - s1 is set at n, s2 at n+1, `pending[i]` at n+2.
  - Earliest `intr` is the cycle after edge n+3, requiring enable and boundary in the cycle after n+2.
- `intr` and `intr_return` are registered FSM decodes and never combinational from inputs.
- `intr` is asserted for exactly one cycle per take. Minimum spacing between two takes is 4 cycles (ACK, ≥1 SERVICE, RET, IDLE).
- Reset asserted mid-operation, in any state: immediate return to IDLE with all outputs 0. Pending requests are discarded.

## Test plan
- Reset: assert `reset` mid-SERVICE -> all outputs 0 immediately, FSM in IDLE, `pending`=0.
- Single request: `irq_in`=4'b0100, `intr_enable`=1, `inst_boundary`=1 every cycle, `pc_next`=32'h40 -> `pending`[2] set 2 edges after the sampling edge. Then a 1-cycle `intr` one edge later with `intr_id`=2, `intr_vector`=264, `epc`=32'h40, `pending`=0.
- Priority: pending=4'b1010, take -> `intr_id`=1, `intr_vector`=260, `pending`=4'b1000. After RETURN, `intr_return` pulses, then the next take gives `intr_id`=3, `intr_vector`=268.
- Disabled accumulation: edges on sources 0 and 2 with `intr_enable`=0 -> `pending`=4'b0101 and no `intr`. Raise `intr_enable` -> take of source 0.
- No nesting / return gating: in SERVICE, raise a new request and present RETURN with `inst_boundary`=0 -> no `intr`, no `intr_return`. Then RETURN with `inst_boundary`=1 -> `intr_return` for 1 cycle, `in_service` drops.
- Set/clear collision: a new edge on source 0 lands on the same edge as its take -> `intr` is issued and `pending`[0] remains 1 afterward.
